sram_arbiter: RTL

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/sram_arbiter.sv | 113 +++++++++++
 1 files changed

// File: rtl/sram_arbiter.sv
// Two-port (fetch / load-store) arbiter in front of a single-port SRAM.
// Data side has priority; the fetch side is forced through after STARVE_LIMIT consecutive losses.
module sram_arbiter #(
    parameter int STARVE_LIMIT = 3
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_gnt,
    output logic        inst_rvalid,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic [3:0]  data_wen,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_gnt,
    output logic        data_rvalid,
    output logic [31:0] data_rdata,

    output logic        ram_en,
    output logic [3:0]  ram_wen,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata,

    output logic        stallreq_for_arb
);

    localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT_V = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE,
        RESP_INST,
        RESP_DATA
    } owner_t;

    owner_t           owner;
    logic [CNT_W-1:0] starve_cnt;
    logic [31:0]      inst_hold;
    logic [31:0]      data_hold;
    logic             starved;
    logic             is_load;

    // Grants are gated by rst so every request-path output reads zero while reset is held.
    always_comb begin
        starved  = (starve_cnt == LIMIT_V);
        is_load  = (data_wen == 4'b0000);
        inst_gnt = rst & inst_req & (~data_req | starved);
        data_gnt = rst & data_req & ~(inst_req & starved);
        stallreq_for_arb = rst & ((inst_req & ~inst_gnt) | (data_req & ~data_gnt));
    end

    always_comb begin
        ram_en    = inst_gnt | data_gnt;
        ram_wen   = 4'b0000;
        ram_addr  = 32'h0000_0000;
        ram_wdata = 32'h0000_0000;
        if (data_gnt) begin
            ram_wen   = data_wen;
            ram_addr  = data_addr;
            ram_wdata = data_wdata;
        end else if (inst_gnt) begin
            ram_addr  = inst_addr;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt <= '0;
        end else if (inst_gnt || !inst_req) begin
            starve_cnt <= '0;
        end else if (!starved) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    // Response owner: the SRAM returns read data one cycle after the grant, so remember who asked.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner       <= IDLE;
            inst_rvalid <= 1'b0;
            data_rvalid <= 1'b0;
            inst_hold   <= 32'h0000_0000;
            data_hold   <= 32'h0000_0000;
        end else begin
            if (owner == RESP_INST) begin
                inst_hold <= ram_rdata;
            end
            if (owner == RESP_DATA) begin
                data_hold <= ram_rdata;
            end
            inst_rvalid <= inst_gnt;
            data_rvalid <= data_gnt & is_load;
            if (inst_gnt) begin
                owner <= RESP_INST;
            end else if (data_gnt && is_load) begin
                owner <= RESP_DATA;
            end else begin
                owner <= IDLE;
            end
        end
    end

    always_comb begin
        inst_rdata = (owner == RESP_INST) ? ram_rdata : inst_hold;
        data_rdata = (owner == RESP_DATA) ? ram_rdata : data_hold;
    end

endmodule
